// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction-memory request/response plus the decoder-facing
// instruction handshake and the redirect command.
interface instruction_fetch_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rvalid;
  logic [31:0]       imem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_rvalid, imem_rdata,
    input  redirect_valid, redirect_pc,
    output instr_valid,
    input  instr_ready,
    output instr, instr_pc
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rvalid, imem_rdata,
    output redirect_valid, redirect_pc,
    input  instr_valid,
    output instr_ready,
    input  instr, instr_pc
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, single-outstanding instruction-memory requests and an
// in-order prefetch FIFO of {pc, word} feeding the decoder.
module instruction_fetch #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                 clk,
  input logic                 rst,
  instruction_fetch_if.master bus
);

  localparam int unsigned      PTR_W = $clog2(DEPTH);
  localparam int unsigned      CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [31:0]       word;
  } entry_t;

  entry_t            r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [ADDR_W-1:0] r_pc, r_inflight_pc;
  logic              r_outstanding, r_discard;

  logic              w_retire, w_push, w_pop, w_issue, w_valid;
  logic [CNT_W-1:0]  w_count_next;

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_valid      = 1'b0;
    w_retire     = 1'b0;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_count_next = r_count;
    w_issue      = 1'b0;

    w_valid  = !rst && (r_count != '0);
    w_retire = bus.imem_rvalid && r_outstanding;
    w_push   = w_retire && !r_discard && !bus.redirect_valid;
    w_pop    = w_valid && bus.instr_ready && !bus.redirect_valid;
    w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    // Room is judged after this cycle's push/pop, so the single in-flight
    // response always has a free slot when it lands.
    w_issue = !rst && !bus.redirect_valid
              && (!r_outstanding || bus.imem_rvalid)
              && (w_count_next < FULL);
  end

  assign bus.imem_req    = w_issue;
  assign bus.imem_addr   = r_pc;
  assign bus.instr_valid = w_valid;
  assign bus.instr       = r_mem[r_rd_ptr].word;
  assign bus.instr_pc    = r_mem[r_rd_ptr].pc;

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_inflight_pc <= '0;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_outstanding <= 1'b0;
      r_discard     <= 1'b0;
      // NOTE: the FIFO storage is cleared here only because instr/instr_pc
      // must read 0 after reset; a redirect flush leaves the storage alone.
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else begin
      if (w_issue)       r_outstanding <= 1'b1;
      else if (w_retire) r_outstanding <= 1'b0;

      if (w_retire)                                 r_discard <= 1'b0;
      else if (bus.redirect_valid && r_outstanding) r_discard <= 1'b1;

      if (bus.redirect_valid) begin
        r_pc     <= bus.redirect_pc;
        r_count  <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_issue) begin
          r_pc          <= r_pc + ADDR_W'(4);
          r_inflight_pc <= r_pc;
        end
        if (w_push) begin
          r_mem[r_wr_ptr] <= '{pc: r_inflight_pc, word: bus.imem_rdata};
          r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_count <= w_count_next;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: an in-order memory model with
// programmable latency answers requests with addr ^ 32'hA5A5_0000.
module tb_instruction_fetch;

  logic clk;
  logic rst;

  instruction_fetch_if #(.ADDR_W(32)) bus ();

  instruction_fetch #(
    .ADDR_W  (32),
    .DEPTH   (4),
    .RESET_PC(32'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t pend[$];
  int   cyc;
  int   lat;
  logic stray;

  logic        s_req, s_valid;
  logic [31:0] s_addr, s_instr, s_pc;

  int n_vec;
  int n_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive memory response, sample outputs mid-cycle,
  // update the memory model, then advance past the rising edge.
  task automatic cycle();
    logic delivered;
    delivered       = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    if (stray) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'hDEAD_BEEF;
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = pend[0].addr ^ 32'hA5A5_0000;
      delivered       = 1'b1;
    end
    #2;
    s_req   = bus.imem_req;
    s_addr  = bus.imem_addr;
    s_valid = bus.instr_valid;
    s_instr = bus.instr;
    s_pc    = bus.instr_pc;
    if (delivered) void'(pend.pop_front());
    if (s_req) pend.push_back('{addr: s_addr, due: cyc + lat});
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int new_lat);
    lat                = new_lat;
    rst                = 1'b1;
    bus.redirect_valid = 1'b0;
    stray              = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (i == 1) begin
        check("rst_req",   s_req,   0);
        check("rst_valid", s_valid, 0);
        check("rst_instr", s_instr, 0);
        check("rst_pc",    s_pc,    0);
      end
    end
    rst = 1'b0;
  endtask

  logic [31:0] exp_addr[4];
  int          nreq, nvalid;

  initial begin
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    lat   = 1;
    stray = 1'b0;
    rst   = 1'b1;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.instr_ready    = 1'b0;
    @(posedge clk);
    #1;

    // Streaming, L=1, decoder always ready
    bus.instr_ready = 1'b1;
    do_reset(1);
    cycle(); check("t1_addr0", {s_req, s_addr}, {1'b1, 32'h0});
    cycle(); check("t1_addr1", {s_req, s_addr}, {1'b1, 32'h4});
             check("t1_nvalid", s_valid, 0);
    cycle(); check("t1_addr2", {s_req, s_addr}, {1'b1, 32'h8});
             check("t1_head0", {s_valid, s_pc, s_instr}, {1'b1, 32'h0, 32'hA5A5_0000});
    cycle(); check("t1_head1", {s_valid, s_pc, s_instr}, {1'b1, 32'h4, 32'hA5A5_0004});
    cycle(); check("t1_head2", {s_valid, s_pc, s_instr}, {1'b1, 32'h8, 32'hA5A5_0008});

    // Fill with decoder stalled, L=2
    bus.instr_ready = 1'b0;
    do_reset(2);
    exp_addr = '{32'h0, 32'h4, 32'h8, 32'hC};
    nreq = 0;
    for (int k = 1; k <= 12; k++) begin
      cycle();
      if (s_req) begin
        if (nreq < 4) check("t2_fill_addr", s_addr, exp_addr[nreq]);
        nreq++;
      end
    end
    check("t2_nreq", nreq, 4);
    check("t2_full_head", {s_valid, s_pc}, {1'b1, 32'h0});
    bus.instr_ready = 1'b1;
    cycle(); check("t2_pop_issue", {s_req, s_addr, s_valid, s_pc}, {1'b1, 32'h10, 1'b1, 32'h0});
    bus.instr_ready = 1'b0;
    cycle(); check("t2_next_head", {s_req, s_valid, s_pc}, {1'b0, 1'b1, 32'h4});

    // Redirect with a response in flight, L=3
    bus.instr_ready = 1'b1;
    do_reset(3);
    for (int k = 1; k <= 7; k++) cycle();
    check("t3_req8", {s_req, s_addr}, {1'b1, 32'h8});
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    cycle(); check("t3_redir_noreq", s_req, 0);
    bus.redirect_valid = 1'b0;
    cycle(); check("t3_valid_drop", s_valid, 0);
             check("t3_wait_stale", s_req, 0);
    nvalid = 0;
    cycle(); check("t3_req100", {s_req, s_addr}, {1'b1, 32'h100});
    if (s_valid) nvalid++;
    for (int k = 11; k <= 13; k++) begin
      cycle();
      if (s_valid) nvalid++;
    end
    check("t3_stale_dropped", nvalid, 0);
    cycle(); check("t3_first_after", {s_valid, s_pc, s_instr}, {1'b1, 32'h100, 32'hA5A5_0100});

    // Redirect coinciding with a response and a pop, L=1
    do_reset(1);
    cycle();
    cycle();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h200;
    cycle(); check("t4_redir_noreq", s_req, 0);
    bus.redirect_valid = 1'b0;
    cycle(); check("t4_empty_req", {s_valid, s_req, s_addr}, {1'b0, 1'b1, 32'h200});
    cycle();
    cycle(); check("t4_head", {s_valid, s_pc, s_instr}, {1'b1, 32'h200, 32'hA5A5_0200});

    // Single-cycle reset mid-request, stale response after reset, L=4
    do_reset(4);
    for (int k = 1; k <= 7; k++) cycle();
    rst = 1'b1;
    cycle(); check("t5_rst_req", s_req, 0);
    rst = 1'b0;
    cycle(); check("t5_restart", {s_req, s_addr, s_valid}, {1'b1, 32'h0, 1'b0});
    nvalid = 0;
    for (int k = 10; k <= 13; k++) begin
      cycle();
      if (s_valid) nvalid++;
    end
    check("t5_stray_ignored", nvalid, 0);
    cycle(); check("t5_head", {s_valid, s_pc, s_instr}, {1'b1, 32'h0, 32'hA5A5_0000});

    // PC wrap at the top of the address space, L=1
    do_reset(1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    cycle();
    bus.redirect_valid = 1'b0;
    cycle(); check("t6_req_top", {s_req, s_addr}, {1'b1, 32'hFFFF_FFFC});
    cycle(); check("t6_wrap", {s_req, s_addr}, {1'b1, 32'h0});
    cycle(); check("t6_head", {s_valid, s_pc, s_instr}, {1'b1, 32'hFFFF_FFFC, 32'h5A5A_FFFC});

    // Stray response while full and idle must not change the FIFO
    bus.instr_ready = 1'b0;
    do_reset(1);
    for (int k = 1; k <= 5; k++) cycle();
    stray = 1'b1;
    cycle(); check("t7_stray_noreq", s_req, 0);
    stray = 1'b0;
    bus.instr_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("t7_drain", {s_valid, s_pc, s_instr},
            {1'b1, 32'(k * 4), 32'(k * 4) ^ 32'hA5A5_0000});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the pipeline: holds the program counter and issues word requests to instruction memory. It buffers returned instructions in a small in-order prefetch FIFO and presents them, with their PC, to the instruction decoder through a valid/ready handshake. A redirect input (branch/exception) flushes the buffer and restarts fetch at a new PC. At most one memory request is in flight at any time.

## Interface
Parameters:
- `ADDR_W`, default 32: PC and memory address width.
- `DEPTH`, default 4: prefetch FIFO entries, power of 2, ≥2.
- `RESET_PC`, default 0: PC loaded on reset.

Ports:
- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `imem_req`, output, 1: request strobe, one cycle per request; memory always accepts it.
- `imem_addr`, output, `ADDR_W`: word address of the request; meaningful only when `imem_req`=1.
- `imem_rvalid`, input, 1: response valid, at least one cycle after its request, in order.
- `imem_rdata`, input, 32: instruction word returned with `imem_rvalid`.
- `redirect_valid`, input, 1: one-cycle restart command.
- `redirect_pc`, input, `ADDR_W`: new fetch PC, sampled when `redirect_valid`=1.
- `instr_valid`, output, 1: FIFO head holds a valid instruction.
- `instr_ready`, input, 1: decoder accepts the head this cycle.
- `instr`, output, 32: head instruction word. The decoder consumes `[31:28]` as the opcode and `[27:16]` as the register fields.
- `instr_pc`, output, `ADDR_W`: address the head instruction was fetched from.

## Operation
- State:
  - `pc`: next fetch address.
  - FIFO of {pc, word}: `count` 0..DEPTH, with wrapping read/write pointers.
  - `outstanding`: one request in flight.
  - `discard`: the in-flight response is stale.
  - A pc register for the in-flight request.
- Push: `imem_rvalid && outstanding && !discard && !redirect_valid` writes {in-flight pc, `imem_rdata`} at the write pointer.
- Pop: `instr_valid && instr_ready && !redirect_valid` advances the read pointer.
- `count_next = count + push - pop`. Push and pop in the same cycle are allowed, including when `count`=DEPTH with a pop.
- Response retire: `imem_rvalid && outstanding` clears `outstanding` and `discard`.
- Stray `imem_rvalid` while `outstanding`=0 is ignored entirely and has no state change.
- Issue condition: `!redirect_valid && (!outstanding || imem_rvalid) && (count_next + 0) < DEPTH`.
  - On issue: `imem_req`=1, `imem_addr`=`pc`, `pc <= pc + 4` modulo 2^ADDR_W (wraps silently), `outstanding <= 1`, in-flight pc <= `pc`.
  - `imem_req` is combinational from `imem_rvalid`, `instr_ready`, `redirect_valid` and registered state.
- FIFO never overflows:
  - Issue requires room after this cycle's push/pop.
  - Only one request can be in flight, so its response always has a slot.
- Redirect (`redirect_valid`=1):
  - `pc <= redirect_pc`; FIFO flushed (`count`, pointers to 0).
  - No push, no pop, no issue this cycle.
  - If a request is in flight and its response is not arriving this cycle: `discard <= 1`. That response is later dropped and `outstanding` is cleared when it arrives.
  - A redirect arriving while `discard` is already set re-loads `pc` only.
  - Fetch from `redirect_pc` begins the first cycle the issue condition holds.
- Reset (`rst`=1, synchronous, any cycle including mid-request):
  - `pc <= RESET_PC`; `count`, pointers, `outstanding` and `discard` cleared.
  - A response to a pre-reset request arrives with `outstanding`=0 and is ignored as stray.
- Output reset values (during and the cycle after reset): `imem_req`=0, `instr_valid`=0, `instr`=0, `instr_pc`=0. `imem_addr` shows `pc`.
- Outputs `instr`/`instr_pc` read the head entry. When `count`=0 they hold the last value and are don't-care.

## Timing
- First request: the cycle after `rst` deasserts, at `imem_addr`=RESET_PC.
- Request at cycle t, response at t+L (L≥1) → `instr_valid`=1 at t+L+1.
- With L=1 and `instr_ready` held 1: one request per cycle, one instruction per cycle sustained.
- Fill from empty takes DEPTH requests when `instr_ready`=0. After that, `imem_req` stays 0 until a pop.
- Redirect at cycle r with nothing in flight: request to `redirect_pc` at r+1. With a stale response in flight: request in the cycle that response arrives, or later.
- `instr_valid` drops to 0 at r+1 after a redirect at r.

## Test plan
- Reset with RESET_PC=0, L=1, `instr_ready`=1, memory returning addr^0xA5A5_0000 → `imem_addr` 0x0,0x4,0x8 on consecutive cycles; `instr_valid` from the 3rd cycle after reset with `instr_pc` 0x0,0x4,0x8 and matching data in order.
- DEPTH=4, `instr_ready`=0, L=2 → exactly 4 requests (0x0..0xC), then `imem_req`=0 while `count`=4. Raise `instr_ready` → request 0x10 issues the same cycle as the first pop.
- L=3, redirect to 0x100 one cycle after the request to 0x8 → the 0x8 response is dropped; next request is 0x100 in the cycle that response arrives; the first `instr_pc` after the redirect is 0x100.
- Redirect in the same cycle as `imem_rvalid`, with `instr_valid`&&`instr_ready` → no push, no pop, FIFO empty next cycle; request to `redirect_pc` the next cycle.
- Assert `rst` one cycle while a request is in flight (L=4), then deliver its `imem_rvalid` → response ignored; first post-reset request at RESET_PC; no entry with the old pc ever appears.
- `pc`=0xFFFF_FFFC with ADDR_W=32 → next `imem_addr` 0x0. Separately, pulse stray `imem_rvalid` with nothing outstanding → `count` unchanged.
